// File: rtl/md_ctrl_e.sv
// md_ctrl_e: EX-stage multiply/divide sequencer owning the HI/LO registers.
// Decodes mult/multu/div/divu/mthi/mtlo/mfhi/mflo in E, computes the result
// at start, holds md_busy for a fixed number of cycles and commits HI/LO at
// the end. stall_md holds a D-stage HI/LO user until the unit is idle.
// Optional feature macro: MD_MADD_EN adds madd/maddu/msub/msubu (SPECIAL2).
//
// Handshake: md_start is a one-cycle launch strobe, asserted only while the
// unit is idle; a start-class instruction seen while md_busy=1 is dropped
// (no restart, no counter change). The pipeline relies on stall_md to keep
// such instructions out of E while busy.
module md_ctrl_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_E,
  input  logic [31:0] rs_data_E,
  input  logic [31:0] rt_data_E,
  input  logic        md_use_D,
  output logic        md_start,
  output logic        md_busy,
  output logic        stall_md,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] md_rdata_E
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic [31:0]   pend_hi_q;
  logic [31:0]   pend_lo_q;

  // Register-number and shamt fields are irrelevant to this unit.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_E[25:6];

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       is_special;
  assign opcode     = instr_E[31:26];
  assign funct      = instr_E[5:0];
  assign is_special = (opcode == 6'b000000);

  logic is_mult, is_multu, is_div, is_divu;
  logic is_mfhi, is_mthi, is_mflo, is_mtlo;
  assign is_mult  = is_special & (funct == 6'b011000);
  assign is_multu = is_special & (funct == 6'b011001);
  assign is_div   = is_special & (funct == 6'b011010);
  assign is_divu  = is_special & (funct == 6'b011011);
  assign is_mfhi  = is_special & (funct == 6'b010000);
  assign is_mthi  = is_special & (funct == 6'b010001);
  assign is_mflo  = is_special & (funct == 6'b010010);
  assign is_mtlo  = is_special & (funct == 6'b010011);

  logic is_madd, is_maddu, is_msub, is_msubu;
`ifdef MD_MADD_EN
  logic is_special2;
  assign is_special2 = (opcode == 6'b011100);
  assign is_madd     = is_special2 & (funct == 6'b000000);
  assign is_maddu    = is_special2 & (funct == 6'b000001);
  assign is_msub     = is_special2 & (funct == 6'b000100);
  assign is_msubu    = is_special2 & (funct == 6'b000101);
`else
  assign is_madd  = 1'b0;
  assign is_maddu = 1'b0;
  assign is_msub  = 1'b0;
  assign is_msubu = 1'b0;
`endif

  logic is_mul_op;
  logic is_div_op;
  logic is_signed_mul;
  assign is_mul_op     = is_mult | is_multu | is_madd | is_maddu | is_msub | is_msubu;
  assign is_div_op     = is_div | is_divu;
  assign is_signed_mul = is_mult | is_madd | is_msub;

  assign md_busy    = (state_q == ST_BUSY);
  assign md_start   = (is_mul_op | is_div_op) & ~md_busy;
  assign stall_md   = md_use_D & (md_start | md_busy);
  assign hi_out     = hi_q;
  assign lo_out     = lo_q;

  // mfhi/mflo read the architectural registers directly.
  always_comb begin
    md_rdata_E = 32'h0;
    if (is_mfhi)      md_rdata_E = hi_q;
    else if (is_mflo) md_rdata_E = lo_q;
  end

  // 64-bit products; the signed one uses sign-extended operands.
  logic signed [63:0] rs_sx;
  logic signed [63:0] rt_sx;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [63:0]        product;
  assign rs_sx   = {{32{rs_data_E[31]}}, rs_data_E};
  assign rt_sx   = {{32{rt_data_E[31]}}, rt_data_E};
  assign prod_s  = 64'(rs_sx * rt_sx);
  assign prod_u  = {32'h0, rs_data_E} * {32'h0, rt_data_E};
  assign product = is_signed_mul ? prod_s : prod_u;

  // Signed divide through magnitudes: the unsigned core never overflows,
  // so 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
  logic        rs_neg, rt_neg, div_zero;
  logic [31:0] abs_rs, abs_rt, divisor, q_mag, r_mag, quot, rem;
  assign rs_neg   = is_div & rs_data_E[31];
  assign rt_neg   = is_div & rt_data_E[31];
  assign abs_rs   = rs_neg ? (32'h0 - rs_data_E) : rs_data_E;
  assign abs_rt   = rt_neg ? (32'h0 - rt_data_E) : rt_data_E;
  assign div_zero = (rt_data_E == 32'h0);
  assign divisor  = div_zero ? 32'd1 : abs_rt;
  assign q_mag    = abs_rs / divisor;
  assign r_mag    = abs_rs % divisor;
  assign quot     = (rs_neg ^ rt_neg) ? (32'h0 - q_mag) : q_mag;
  assign rem      = rs_neg ? (32'h0 - r_mag) : r_mag;

  // Value to commit into {HI,LO}; divide by zero re-commits the old value.
  logic [63:0] result;
  always_comb begin
    result = product;
    if (is_div_op)                 result = div_zero ? {hi_q, lo_q} : {rem, quot};
    else if (is_madd | is_maddu)   result = {hi_q, lo_q} + product;
    else if (is_msub | is_msubu)   result = {hi_q, lo_q} - product;
  end

  // IDLE/BUSY sequencer: launch latches the result, BUSY counts down and
  // commits HI/LO on the edge where the counter reads 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= 32'h0;
      pend_lo_q <= 32'h0;
      hi_q      <= 32'h0;
      lo_q      <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (md_start) begin
            pend_hi_q <= result[63:32];
            pend_lo_q <= result[31:0];
            cnt_q     <= is_div_op ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state_q   <= ST_BUSY;
          end else begin
            if (is_mthi) hi_q <= rs_data_E;
            if (is_mtlo) lo_q <= rs_data_E;
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            hi_q    <= pend_hi_q;
            lo_q    <= pend_lo_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_ctrl_e.sv
// tb_md_ctrl_e: directed and randomized checks of md_ctrl_e against a
// behavioural model of HI/LO arithmetic and busy/stall timing.
module tb_md_ctrl_e;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [31:0] I_NOP   = 32'h0000_0000;
  localparam logic [31:0] I_MULT  = 32'h0000_0018;
  localparam logic [31:0] I_MULTU = 32'h0000_0019;
  localparam logic [31:0] I_DIV   = 32'h0000_001A;
  localparam logic [31:0] I_DIVU  = 32'h0000_001B;
  localparam logic [31:0] I_MFHI  = 32'h0000_0010;
  localparam logic [31:0] I_MTHI  = 32'h0000_0011;
  localparam logic [31:0] I_MFLO  = 32'h0000_0012;
  localparam logic [31:0] I_MTLO  = 32'h0000_0013;
  localparam logic [31:0] I_MADDU = 32'h7000_0001;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_E, rs_data_E, rt_data_E;
  logic        md_use_D;
  logic        md_start, md_busy, stall_md;
  logic [31:0] hi_out, lo_out, md_rdata_E;

  always #5 clk = ~clk;

  md_ctrl_e #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .instr_E(instr_E),
    .rs_data_E(rs_data_E), .rt_data_E(rt_data_E), .md_use_D(md_use_D),
    .md_start(md_start), .md_busy(md_busy), .stall_md(stall_md),
    .hi_out(hi_out), .lo_out(lo_out), .md_rdata_E(md_rdata_E)
  );

  // scoreboard state
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_hi  = 32'h0;
  logic [31:0] m_lo  = 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural result of one HI/LO instruction.
  function automatic logic [63:0] model(input logic [31:0] ins, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (ins[5:0])
      6'h18: return 64'(sa * sb);
      6'h19: return ua * ub;
      6'h1A, 6'h1B: begin
        if (b == 32'h0) return hl;
        if (ins[5:0] == 6'h1B) begin sa = longint'(ua); sb = longint'(ub); end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return hl + (ua * ub); // maddu, only used with MD_MADD_EN
    endcase
  endfunction

  function automatic logic [31:0] with_fields(input logic [31:0] ins);
    return ins | ($urandom & 32'h03FF_FFC0);
  endfunction

  // Launch one md operation and follow it through busy to commit.
  task automatic do_md(input string tag, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic use_d, input logic intrude);
    logic [63:0] exp;
    int          n;
    exp = model(ins, a, b, {m_hi, m_lo});
    n   = (ins[5:1] == 5'b01101) ? DC : MC;
    @(negedge clk);
    instr_E = with_fields(ins); rs_data_E = a; rt_data_E = b; md_use_D = use_d;
    #1;
    chk({tag, "_start"}, md_start, 1'b1);
    chk({tag, "_stall0"}, stall_md, use_d);
    chk({tag, "_busy0"}, md_busy, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      instr_E = I_NOP; rs_data_E = $urandom; rt_data_E = $urandom; md_use_D = use_d;
      if (intrude && i == 1) instr_E = with_fields(I_MULT);
      if (intrude && i == 2) instr_E = with_fields(I_MTHI);
      #1;
      chk($sformatf("%s_busy%0d", tag, i + 1), md_busy, 1'b1);
      chk($sformatf("%s_stall%0d", tag, i + 1), stall_md, use_d);
      chk($sformatf("%s_hold%0d", tag, i + 1), {hi_out, lo_out}, {m_hi, m_lo});
      if (intrude && i == 1) chk({tag, "_nostart"}, md_start, 1'b0);
    end
    @(negedge clk);
    instr_E = I_NOP; md_use_D = use_d;
    #1;
    {m_hi, m_lo} = exp;
    chk({tag, "_done"}, md_busy, 1'b0);
    chk({tag, "_release"}, stall_md, 1'b0);
    chk({tag, "_hilo"}, {hi_out, lo_out}, {m_hi, m_lo});
  endtask

  task automatic move_to(input logic to_hi, input logic [31:0] v);
    @(negedge clk);
    instr_E = with_fields(to_hi ? I_MTHI : I_MTLO); rs_data_E = v; rt_data_E = $urandom;
    md_use_D = 1'b0;
    #1;
    chk("mt_start", md_start, 1'b0);
    chk("mt_rdata", md_rdata_E, 32'h0);
    @(negedge clk);
    instr_E = I_NOP;
    #1;
    if (to_hi) m_hi = v; else m_lo = v;
    chk("mt_hilo", {hi_out, lo_out}, {m_hi, m_lo});
  endtask

  task automatic read_back(input string tag);
    @(negedge clk);
    instr_E = with_fields(I_MFHI); #1;
    chk({tag, "_mfhi"}, md_rdata_E, m_hi);
    instr_E = with_fields(I_MFLO); #1;
    chk({tag, "_mflo"}, md_rdata_E, m_lo);
    instr_E = I_NOP;
  endtask

  initial begin
    logic [31:0] ins, a, b;
    int          sel;
    reset_n = 1'b0; instr_E = I_NOP; rs_data_E = 32'h0; rt_data_E = 32'h0; md_use_D = 1'b0;
    #1;
    chk("rst_busy", md_busy, 1'b0);
    chk("rst_hilo", {hi_out, lo_out}, 64'h0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // directed arithmetic cases
    do_md("mult",  I_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    do_md("multu", I_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    do_md("div",   I_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    do_md("divu",  I_DIVU,  32'd7, 32'd2, 1'b0, 1'b0);
    do_md("divov", I_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // stall with a D-stage mflo, then mflo reaches E
    do_md("stall", I_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    read_back("stall");

    // second mult and mthi while busy are dropped
    do_md("ovlp", I_MULT, 32'd1000, 32'hFFFF_FF00, 1'b0, 1'b1);
    read_back("ovlp");

    // divide by zero keeps prior HI/LO
    move_to(1'b1, 32'h11);
    move_to(1'b0, 32'h22);
    do_md("div0", I_DIV, 32'd5, 32'd0, 1'b0, 1'b0);

    // asynchronous reset in busy cycle 3 of a div
    @(negedge clk);
    instr_E = I_DIV; rs_data_E = 32'd100; rt_data_E = 32'd7; md_use_D = 1'b0;
    #1;
    chk("arst_start", md_start, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      instr_E = I_NOP;
    end
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", md_busy, 1'b0);
    chk("arst_hilo", {hi_out, lo_out}, 64'h0);
    m_hi = 32'h0; m_lo = 32'h0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    repeat (DC + 2) @(negedge clk);
    #1;
    chk("arst_nocommit_busy", md_busy, 1'b0);
    chk("arst_nocommit_hilo", {hi_out, lo_out}, 64'h0);

`ifdef MD_MADD_EN
    move_to(1'b1, 32'h0);
    move_to(1'b0, 32'hFFFF_FFFF);
    do_md("maddu", I_MADDU, 32'd1, 32'd1, 1'b0, 1'b0);
`else
    @(negedge clk);
    instr_E = I_MADDU; rs_data_E = 32'd1; rt_data_E = 32'd1; md_use_D = 1'b1;
    #1;
    chk("madd_nostart", md_start, 1'b0);
    chk("madd_nostall", stall_md, 1'b0);
    @(negedge clk);
    instr_E = I_NOP; md_use_D = 1'b0;
    #1;
    chk("madd_nobusy", md_busy, 1'b0);
    chk("madd_hilo", {hi_out, lo_out}, {m_hi, m_lo});
`endif

    // randomized mix
    for (int k = 0; k < 16; k++) begin
      sel = $urandom_range(0, 5);
      a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b   = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      if (sel >= 4) begin
        move_to(sel == 4, a);
      end else begin
        case (sel)
          0:       ins = I_MULT;
          1:       ins = I_MULTU;
          2:       ins = I_DIV;
          default: ins = I_DIVU;
        endcase
        do_md($sformatf("rnd%0d", k), ins, a, b, 1'(k % 2), 1'b0);
      end
      read_back($sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_ctrl_e.md
Name: md_ctrl_E

Overview:
- Multiply/divide sequencer for the EX stage of the five-stage MIPS pipeline; owns the HI/LO registers.
- Decodes the E-stage instruction for mult/multu/div/divu/mthi/mtlo/mfhi/mflo and launches a fixed-latency operation.
- Holds busy for the programmed number of cycles and commits HI/LO at completion.
- Raises a stall request to the hazard unit while a D-stage HI/LO user must wait.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  input  1  pipeline clock
- reset_n  input  1  asynchronous active-low reset
- instr_E  input  32  instruction currently in E
- rs_data_E  input  32  forwarded rs operand
- rt_data_E  input  32  forwarded rt operand
- md_use_D  input  1  D-stage instruction is mult/div/mthi/mtlo/mfhi/mflo (from D decoder)
- md_start  output  1  E instr is mult/multu/div/divu and unit idle (combinational)
- md_busy  output  1  operation in progress (registered)
- stall_md  output  1  md_use_D & (md_start | md_busy)
- hi_out  output  32  HI register value
- lo_out  output  32  LO register value
- md_rdata_E  output  32  mfhi→HI, mflo→LO, else 0

Behaviour:
- Clocking and reset: one clock, clk. reset_n is asynchronous and active-low. On reset: HI=0, LO=0, md_busy=0, counter=0, pending regs=0, state=IDLE. Reset mid-operation aborts it with no commit.
- Decode: opcode 000000 with funct 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo. Anything else is a no-op.
- FSM, two states, IDLE and BUSY:
  - IDLE: if md_start, latch the result into pending_hi/pending_lo, load counter = MULT_CYCLES or DIV_CYCLES, go to BUSY.
  - BUSY: counter decrements each edge. At the edge where counter==1, write HI←pending_hi and LO←pending_lo, clear busy, go to IDLE.
  - Net effect: md_busy is high for exactly N cycles after the start cycle. New HI/LO are visible in the cycle md_busy first reads 0.
- Arithmetic:
  - mult: signed 64-bit product {HI,LO}. multu: unsigned.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. divu: unsigned.
  - Divide by zero: still takes DIV_CYCLES, and HI/LO keep their prior values.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo: in IDLE, write HI/LO ← rs_data_E at the clock edge. While busy, ignored (the stall guarantees this never occurs legally).
- mfhi/mflo: md_rdata_E is combinational from the HI/LO registers.
- Overlap: md_start is gated by !md_busy. A start presented while busy is ignored, with no restart and no counter change.
- Stall timing: stall_md is purely combinational. A D-stage md user stalls during the start cycle and all N busy cycles. It is released in the first cycle md_busy=0.

Optional Feature:
- Macro MD_MADD_EN.
- When defined, also decode opcode 011100 with funct 000000 madd, 000001 maddu, 000100 msub, 000101 msubu. These use MULT_CYCLES.
- The pending value is {HI,LO} ± product (64-bit wrap). The HI/LO operand is sampled at start, which is legal because the unit is idle then.
- md_use_D must cover these opcodes too; that is the D decoder's responsibility.
- When not defined, these encodings are no-ops: no start, no busy.

Test Plan:
- mult rs=0xFFFFFFFE, rt=3 → md_busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div rs=0xFFFFFFF9 (-7), rt=2 → busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 → LO=3, HI=1.
- div rs=5, rt=0 with HI=0x11, LO=0x22 preset via mthi/mtlo → busy 10 cycles, HI/LO unchanged at 0x11/0x22.
- mult followed by mflo in D (md_use_D=1) → stall_md high in the start cycle plus 5 busy cycles, then low. md_rdata_E returns the new LO once mflo reaches E.
- Second mult presented while busy → ignored: counter and pending values unchanged, only the first result is committed.
- reset_n pulled low on busy cycle 3 of a div → md_busy, HI and LO go to 0 immediately (asynchronously), no commit after release. With MD_MADD_EN: HI=0, LO=0xFFFFFFFF, then maddu 1×1 → HI=1, LO=0.
